fork_join_ctrl: RTL and testbench



---
 rtl/fork_join_ctrl.sv | 131 +++++++++++++
 tb/tb_fork_join_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_join_ctrl.sv
// Fork/join thread scheduler: launches N_THREADS countdown jobs from one start pulse and
// signals join-all / join-any / join-none completion. Define FORK_JOIN_KILL_EN for disable-fork.
module fork_join_ctrl #(
  parameter int unsigned N_THREADS = 3,
  parameter int unsigned DLY_W     = 5,
  localparam int unsigned ID_W     = ($clog2(N_THREADS) > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [N_THREADS*DLY_W-1:0]   delay_bus,
  output logic                         busy,
  output logic [N_THREADS-1:0]         active,
  output logic [N_THREADS-1:0]         thread_done,
  output logic                         join_done,
  output logic [ID_W-1:0]              first_id,
  output logic                         start_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [1:0] ModeAny  = 2'd1;
  localparam logic [1:0] ModeNone = 2'd2;

  state_e                            state_q, state_d;
  logic [N_THREADS-1:0][DLY_W-1:0]   cnt_q, cnt_d;
  logic [N_THREADS-1:0]              act_q, act_d;
  logic [1:0]                        mode_q, mode_d;
  logic                              fired_q, fired_d;
  logic                              seen_q, seen_d;

  logic                              busy_d, join_d, err_d;
  logic [N_THREADS-1:0]              active_d, done_d;
  logic [ID_W-1:0]                   first_id_d, low_id;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    mode_d     = mode_q;
    fired_d    = fired_q;
    seen_d     = seen_q;
    first_id_d = first_id;
    done_d     = '0;
    join_d     = 1'b0;
    err_d      = 1'b0;
    low_id     = '0;
    busy_d     = (state_q == StRun);
    active_d   = act_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int i = 0; i < int'(N_THREADS); i++) begin
            cnt_d[i] = delay_bus[i*DLY_W +: DLY_W];
          end
          act_d   = '1;
          mode_d  = mode;
          fired_d = 1'b0;
          seen_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        err_d = start;
        for (int i = 0; i < int'(N_THREADS); i++) begin
          if (act_q[i]) begin
            if (cnt_q[i] == '0) done_d[i] = 1'b1;
            else                cnt_d[i]  = cnt_q[i] - 1'b1;
          end
        end
        act_d = act_q & ~done_d;

        // Descending scan leaves the lowest completing index in low_id.
        for (int i = int'(N_THREADS) - 1; i >= 0; i--) begin
          if (done_d[i]) low_id = ID_W'(i);
        end
        if (!seen_q && (|done_d)) begin
          seen_d     = 1'b1;
          first_id_d = low_id;
        end

        unique case (mode_q)
          ModeAny:  join_d = !fired_q && (|done_d);
          ModeNone: join_d = !fired_q;
          default:  join_d = !fired_q && (|done_d) && (act_d == '0);
        endcase
        if (join_d) fired_d = 1'b1;

`ifdef FORK_JOIN_KILL_EN
        if (join_d && (mode_q == ModeAny)) act_d = '0;
`endif

        if (act_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      act_q       <= '0;
      mode_q      <= '0;
      fired_q     <= 1'b0;
      seen_q      <= 1'b0;
      busy        <= 1'b0;
      active      <= '0;
      thread_done <= '0;
      join_done   <= 1'b0;
      first_id    <= '0;
      start_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      mode_q      <= mode_d;
      fired_q     <= fired_d;
      seen_q      <= seen_d;
      busy        <= busy_d;
      active      <= active_d;
      thread_done <= done_d;
      join_done   <= join_d;
      first_id    <= first_id_d;
      start_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed bench for fork_join_ctrl (3 threads, 5-bit delays). Cycle k = value seen at the
// falling edge following the k-th rising edge after the start-accepting edge T.
module tb_fork_join_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [14:0] delay_bus;
  logic        busy;
  logic [2:0]  active;
  logic [2:0]  thread_done;
  logic        join_done;
  logic [1:0]  first_id;
  logic        start_err;

  int errors = 0;
  int checks = 0;

  logic [2:0] tdh [0:15];
  logic [2:0] ach [0:15];
  logic       jdh [0:15];
  logic       bzh [0:15];
  logic [1:0] fih [0:15];
  logic       seh [0:15];

  fork_join_ctrl #(.N_THREADS(3), .DLY_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .delay_bus   (delay_bus),
    .busy        (busy),
    .active      (active),
    .thread_done (thread_done),
    .join_done   (join_done),
    .first_id    (first_id),
    .start_err   (start_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive start for one edge; returns at the falling edge of cycle T.
  task automatic launch(input logic [1:0] m, input int d0, input int d1, input int d2);
    @(negedge clk);
    mode      = m;
    delay_bus = {d2[4:0], d1[4:0], d0[4:0]};
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tdh[k] = thread_done; ach[k] = active; jdh[k] = join_done;
      bzh[k] = busy;        fih[k] = first_id; seh[k] = start_err;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; delay_bus = '0;
    idle(3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy, active, thread_done, join_done, first_id, start_err} !== 11'b0) begin
        errors++;
        $display("FAIL reset_outputs got=%b exp=0",
                 {busy, active, thread_done, join_done, first_id, start_err});
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_join_any;
    logic [2:0] etd, eac;
    logic       ejd, ebz;
    launch(2'd1, 7, 5, 2);
    capture(12);
    for (int k = 1; k <= 12; k++) begin
`ifdef FORK_JOIN_KILL_EN
      etd = {(k == 3), 1'b0, 1'b0};
      ebz = (k <= 3);
      eac = (k <= 3) ? 3'b111 : 3'b000;
`else
      etd = {(k == 3), (k == 6), (k == 8)};
      ebz = (k <= 8);
      eac = {(k <= 3), (k <= 6), (k <= 8)};
`endif
      ejd = (k == 3);
      checks++;
      if (tdh[k] !== etd) begin
        errors++; $display("FAIL any_thread_done k=%0d got=%b exp=%b", k, tdh[k], etd);
      end
      checks++;
      if (jdh[k] !== ejd) begin
        errors++; $display("FAIL any_join_done k=%0d got=%b exp=%b", k, jdh[k], ejd);
      end
      checks++;
      if (bzh[k] !== ebz) begin
        errors++; $display("FAIL any_busy k=%0d got=%b exp=%b", k, bzh[k], ebz);
      end
      checks++;
      if (ach[k] !== eac) begin
        errors++; $display("FAIL any_active k=%0d got=%b exp=%b", k, ach[k], eac);
      end
    end
    checks++;
    if (fih[3] !== 2'd2) begin
      errors++; $display("FAIL any_first_id got=%0d exp=2", fih[3]);
    end
    idle(2);
  endtask

  task automatic test_join_any_tie;
    launch(2'd1, 4, 4, 4);
    capture(7);
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (tdh[k] !== ((k == 5) ? 3'b111 : 3'b000)) begin
        errors++; $display("FAIL tie_thread_done k=%0d got=%b", k, tdh[k]);
      end
      checks++;
      if (jdh[k] !== (k == 5)) begin
        errors++; $display("FAIL tie_join_done k=%0d got=%b exp=%b", k, jdh[k], (k == 5));
      end
    end
    checks++;
    if (fih[5] !== 2'd0) begin
      errors++; $display("FAIL tie_first_id got=%0d exp=0", fih[5]);
    end
    checks++;
    if (bzh[6] !== 1'b0) begin
      errors++; $display("FAIL tie_busy_low got=%b exp=0", bzh[6]);
    end
    idle(2);
  endtask

  task automatic test_join_all;
    launch(2'd0, 7, 5, 2);
    capture(10);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (jdh[k] !== (k == 8)) begin
        errors++; $display("FAIL all_join_done k=%0d got=%b exp=%b", k, jdh[k], (k == 8));
      end
    end
    checks++;
    if (fih[8] !== 2'd2) begin
      errors++; $display("FAIL all_first_id got=%0d exp=2", fih[8]);
    end
    checks++;
    if (tdh[8] !== 3'b001) begin
      errors++; $display("FAIL all_last_done got=%b exp=001", tdh[8]);
    end
    idle(2);
  endtask

  task automatic test_join_reserved;
    // Mode 3 behaves as join-all: last finisher (delay 3) at T+4.
    launch(2'd3, 1, 3, 0);
    capture(6);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (jdh[k] !== (k == 4)) begin
        errors++; $display("FAIL rsv_join_done k=%0d got=%b exp=%b", k, jdh[k], (k == 4));
      end
    end
    checks++;
    if (fih[4] !== 2'd2) begin
      errors++; $display("FAIL rsv_first_id got=%0d exp=2", fih[4]);
    end
    idle(2);
  endtask

  task automatic test_join_none;
    logic [2:0] etd;
    launch(2'd2, 3, 0, 6);
    capture(9);
    for (int k = 1; k <= 9; k++) begin
      etd = {(k == 7), (k == 1), (k == 4)};
      checks++;
      if (tdh[k] !== etd) begin
        errors++; $display("FAIL none_thread_done k=%0d got=%b exp=%b", k, tdh[k], etd);
      end
      checks++;
      if (jdh[k] !== (k == 1)) begin
        errors++; $display("FAIL none_join_done k=%0d got=%b exp=%b", k, jdh[k], (k == 1));
      end
      checks++;
      if (bzh[k] !== (k <= 7)) begin
        errors++; $display("FAIL none_busy k=%0d got=%b exp=%b", k, bzh[k], (k <= 7));
      end
    end
    checks++;
    if (fih[1] !== 2'd1) begin
      errors++; $display("FAIL none_first_id got=%0d exp=1", fih[1]);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [2:0] etd;
    launch(2'd0, 7, 5, 2);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      tdh[k] = thread_done; seh[k] = start_err; bzh[k] = busy;
      // Edges T+2 and T+8 see start rejected; T+9 accepts a new fork.
      start = (k == 1 || k == 7 || k == 8);
      delay_bus = (k == 1) ? 15'd0 : {5'd2, 5'd5, 5'd7};
      mode = (k == 1) ? 2'd2 : 2'd0;
    end
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      etd = {(k == 3 || k == 12), (k == 6), (k == 8)};
      checks++;
      if (seh[k] !== (k == 2 || k == 8)) begin
        errors++; $display("FAIL b2b_start_err k=%0d got=%b", k, seh[k]);
      end
      checks++;
      if (tdh[k] !== etd) begin
        errors++; $display("FAIL b2b_thread_done k=%0d got=%b exp=%b", k, tdh[k], etd);
      end
    end
    checks++;
    if (bzh[9] !== 1'b0 || bzh[10] !== 1'b1) begin
      errors++; $display("FAIL b2b_busy_gap got=%b%b exp=01", bzh[9], bzh[10]);
    end
    idle(8);
  endtask

  task automatic test_reset_mid_run;
    launch(2'd0, 7, 5, 2);
    idle(3);
    rst_n = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      @(negedge clk);
      if (k == 5) rst_n = 1'b1;
      checks++;
      if ({busy, active, thread_done, join_done, start_err} !== 9'b0) begin
        errors++;
        $display("FAIL midrst_quiet k=%0d got=%b exp=0", k,
                 {busy, active, thread_done, join_done, start_err});
      end
    end
    launch(2'd1, 0, 1, 1);
    capture(3);
    checks++;
    if (tdh[1] !== 3'b001 || jdh[1] !== 1'b1) begin
      errors++; $display("FAIL midrst_restart got=%b/%b exp=001/1", tdh[1], jdh[1]);
    end
    checks++;
    if (tdh[2] !== 3'b110) begin
      errors++; $display("FAIL midrst_tail got=%b exp=110", tdh[2]);
    end
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = '0; delay_bus = '0;
    test_reset;
    test_join_any;
    test_join_any_tie;
    test_join_all;
    test_join_reserved;
    test_join_none;
    test_back_to_back;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
